// File: rtl/snn_step_controller.sv
// Timestep/layer/row sequencer for a spiking-network accelerator.
// Walks CLR/ACC/UPD/WB per layer and timestep; all outputs registered.
module snn_step_controller #(
  parameter int N_ROWS   = 4,
  parameter int N_LAYERS = 2,
  parameter int N_TSTEPS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [8:0] w_read_sram_addr,
  output logic [8:0] in_spk_read_sram_addr,
  output logic [8:0] u_read_sram_addr,
  output logic [8:0] u_write_sram_addr,
  output logic [8:0] spk_write_sram_addr,
  output logic       spk_write_sram_we,
  output logic       cntrl_ac_reset,
  output logic       cntrl_ac_oen,
  output logic       cntrl_neu_ien,
  output logic       cntrl_spk_select
);

  typedef enum logic [2:0] {
    IDLE, CLR, ACC, UPD, WB, FIN
  } state_t;

  state_t     state, nxt_state;
  logic [8:0] tstep, nxt_tstep;
  logic [8:0] layer, nxt_layer;
  logic [8:0] row, nxt_row;

  logic       nxt_busy, nxt_done, nxt_we;
  logic       nxt_ac_reset, nxt_ac_oen;
  logic       nxt_neu_ien, nxt_sel;
  logic [8:0] nxt_w, nxt_in_spk, nxt_u_rd;
  logic [8:0] nxt_u_wr, nxt_spk_wr;

  always_comb begin
    nxt_state = state;
    nxt_tstep = tstep;
    nxt_layer = layer;
    nxt_row   = row;
    unique case (state)
      IDLE: if (start) begin
        nxt_state = CLR;
        nxt_tstep = '0;
        nxt_layer = '0;
        nxt_row   = '0;
      end
      CLR: begin
        nxt_state = ACC;
        nxt_row   = '0;
      end
      ACC: begin
        if (row == 9'(N_ROWS - 1))
          nxt_state = UPD;
        else
          nxt_row = row + 9'd1;
      end
      UPD: nxt_state = WB;
      WB: begin
        if (layer < 9'(N_LAYERS - 1)) begin
          nxt_layer = layer + 9'd1;
          nxt_state = CLR;
        end else if (tstep < 9'(N_TSTEPS - 1)) begin
          nxt_layer = '0;
          nxt_tstep = tstep + 9'd1;
          nxt_state = CLR;
        end else begin
          nxt_state = FIN;
        end
      end
      FIN: nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    // abort beats every transition, including WB and FIN
    if (abort && state != IDLE)
      nxt_state = IDLE;
  end

  // Outputs are computed for the upcoming state so they align with it.
  always_comb begin
    nxt_busy     = nxt_state != IDLE;
    nxt_done     = nxt_state == FIN;
    nxt_ac_reset = nxt_state == CLR;
    nxt_ac_oen   = nxt_state == ACC;
    nxt_neu_ien  = nxt_state == UPD;
    nxt_we       = nxt_state == WB;
    nxt_sel      = 1'b0;
    nxt_w        = w_read_sram_addr;
    nxt_in_spk   = in_spk_read_sram_addr;
    nxt_u_rd     = u_read_sram_addr;
    nxt_u_wr     = u_write_sram_addr;
    nxt_spk_wr   = spk_write_sram_addr;
    if (nxt_state != IDLE) begin
      nxt_sel    = nxt_layer != '0;
      nxt_in_spk = nxt_tstep;
    end
    if (nxt_state == CLR)
      nxt_u_rd = nxt_layer;
    if (nxt_state == ACC)
      nxt_w = nxt_layer * 9'(N_ROWS) + nxt_row;
    if (nxt_state == WB) begin
      nxt_u_wr   = nxt_layer;
      nxt_spk_wr = nxt_layer * 9'(N_TSTEPS) + nxt_tstep;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      tstep                 <= '0;
      layer                 <= '0;
      row                   <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      w_read_sram_addr      <= '0;
      in_spk_read_sram_addr <= '0;
      u_read_sram_addr      <= '0;
      u_write_sram_addr     <= '0;
      spk_write_sram_addr   <= '0;
      spk_write_sram_we     <= 1'b0;
      cntrl_ac_reset        <= 1'b0;
      cntrl_ac_oen          <= 1'b0;
      cntrl_neu_ien         <= 1'b0;
      cntrl_spk_select      <= 1'b0;
    end else begin
      state                 <= nxt_state;
      tstep                 <= nxt_tstep;
      layer                 <= nxt_layer;
      row                   <= nxt_row;
      busy                  <= nxt_busy;
      done                  <= nxt_done;
      w_read_sram_addr      <= nxt_w;
      in_spk_read_sram_addr <= nxt_in_spk;
      u_read_sram_addr      <= nxt_u_rd;
      u_write_sram_addr     <= nxt_u_wr;
      spk_write_sram_addr   <= nxt_spk_wr;
      spk_write_sram_we     <= nxt_we;
      cntrl_ac_reset        <= nxt_ac_reset;
      cntrl_ac_oen          <= nxt_ac_oen;
      cntrl_neu_ien         <= nxt_neu_ien;
      cntrl_spk_select      <= nxt_sel;
    end
  end

endmodule

// File: tb/tb_snn_step_controller.sv
// Directed bench for snn_step_controller at default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_snn_step_controller;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic       busy, done;
  logic [8:0] w_addr, in_addr, u_rd, u_wr, spk_wr;
  logic       we, ac_reset, ac_oen, neu_ien, sel;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  snn_step_controller dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .abort                 (abort),
    .busy                  (busy),
    .done                  (done),
    .w_read_sram_addr      (w_addr),
    .in_spk_read_sram_addr (in_addr),
    .u_read_sram_addr      (u_rd),
    .u_write_sram_addr     (u_wr),
    .spk_write_sram_addr   (spk_wr),
    .spk_write_sram_we     (we),
    .cntrl_ac_reset        (ac_reset),
    .cntrl_ac_oen          (ac_oen),
    .cntrl_neu_ien         (neu_ien),
    .cntrl_spk_select      (sel)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [6:0]  strb;
    logic [44:0] addrs;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    strb  = {busy, done, we, ac_reset, ac_oen, neu_ien, sel};
    addrs = {w_addr, in_addr, u_rd, u_wr, spk_wr};
    total++;
    if (strb !== 7'd0)
      $display("FAIL reset_strobes got %b want 0", strb);
    else passed++;
    total++;
    if (addrs !== 45'd0)
      $display("FAIL reset_addrs got %h want 0", addrs);
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0)
      $display("FAIL idle_no_start busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_full_run();
    logic [8:0] w_seen[$];
    logic [8:0] exp_w[16];
    logic [8:0] we_a[$], we_u[$], we_i[$];
    logic       we_s[$];
    logic [8:0] clr_u[$];
    logic [8:0] exp_spk[4];
    logic [8:0] exp_lay[4];
    logic [8:0] exp_ts[4];
    int n_busy, n_nien, done_cyc;
    exp_w   = '{0,1,2,3,4,5,6,7,0,1,2,3,4,5,6,7};
    exp_spk = '{0,2,1,3};
    exp_lay = '{0,1,0,1};
    exp_ts  = '{0,0,1,1};
    n_busy = 0;
    n_nien = 0;
    done_cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (busy) n_busy++;
      if (neu_ien) n_nien++;
      if (ac_oen) w_seen.push_back(w_addr);
      if (ac_reset) clr_u.push_back(u_rd);
      if (we) begin
        we_a.push_back(spk_wr);
        we_u.push_back(u_wr);
        we_i.push_back(in_addr);
        we_s.push_back(sel);
      end
      tick();
    end
    total++;
    if (done_cyc != 29)
      $display("FAIL run_done_cycle got %0d want 29", done_cyc);
    else passed++;
    total++;
    if (n_busy != 28)
      $display("FAIL run_busy_cycles got %0d want 28", n_busy);
    else passed++;
    total++;
    if (n_nien != 4)
      $display("FAIL run_neu_ien got %0d want 4", n_nien);
    else passed++;
    total++;
    if (clr_u.size() != 4)
      $display("FAIL run_ac_reset got %0d want 4", clr_u.size());
    else passed++;
    for (int i = 0; i < clr_u.size() && i < 4; i++) begin
      total++;
      if (clr_u[i] !== exp_lay[i])
        $display("FAIL clr_u_rd[%0d] got %0d want %0d",
                 i, clr_u[i], exp_lay[i]);
      else passed++;
    end
    total++;
    if (w_seen.size() != 16)
      $display("FAIL run_acc_cycles got %0d want 16", w_seen.size());
    else passed++;
    for (int i = 0; i < w_seen.size() && i < 16; i++) begin
      total++;
      if (w_seen[i] !== exp_w[i])
        $display("FAIL w_addr[%0d] got %0d want %0d",
                 i, w_seen[i], exp_w[i]);
      else passed++;
    end
    total++;
    if (we_a.size() != 4)
      $display("FAIL run_we_count got %0d want 4", we_a.size());
    else passed++;
    for (int i = 0; i < we_a.size() && i < 4; i++) begin
      total++;
      if (we_a[i] !== exp_spk[i])
        $display("FAIL spk_wr[%0d] got %0d want %0d",
                 i, we_a[i], exp_spk[i]);
      else passed++;
      total++;
      if (we_u[i] !== exp_lay[i])
        $display("FAIL u_wr[%0d] got %0d want %0d",
                 i, we_u[i], exp_lay[i]);
      else passed++;
      total++;
      if (we_i[i] !== exp_ts[i])
        $display("FAIL in_spk[%0d] got %0d want %0d",
                 i, we_i[i], exp_ts[i]);
      else passed++;
      total++;
      if (we_s[i] !== exp_lay[i][0])
        $display("FAIL spk_sel[%0d] got %b want %b",
                 i, we_s[i], exp_lay[i][0]);
      else passed++;
    end
    tick();
    total++;
    if ({busy, done} !== 2'b00)
      $display("FAIL run_after_done busy,done=%b want 00",
               {busy, done});
    else passed++;
  endtask

  task automatic test_abort();
    int found, n_done, n_busy, done_cyc;
    found = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (we) begin
        found = c;
        break;
      end
      tick();
    end
    total++;
    if (found != 7)
      $display("FAIL abort_first_wb got %0d want 7", found);
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, done, we} !== 3'b000)
      $display("FAIL abort_next busy,done,we=%b want 000",
               {busy, done, we});
    else passed++;
    n_done = 0;
    n_busy = 0;
    for (int c = 0; c < 35; c++) begin
      if (done) n_done++;
      if (busy) n_busy++;
      tick();
    end
    total++;
    if (n_done + n_busy != 0)
      $display("FAIL abort_quiet done=%0d busy=%0d want 0",
               n_done, n_busy);
    else passed++;
    done_cyc = 0;
    n_busy = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      if (busy) n_busy++;
      tick();
    end
    total++;
    if (done_cyc != 29 || n_busy != 28)
      $display("FAIL abort_rerun done@%0d busy=%0d want 29/28",
               done_cyc, n_busy);
    else passed++;
    tick();
  endtask

  task automatic test_async_reset();
    logic [6:0]  strb;
    logic [44:0] addrs;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (ac_oen !== 1'b1 || w_addr !== 9'd1)
      $display("FAIL mid_acc oen=%b w=%0d want 1/1",
               ac_oen, w_addr);
    else passed++;
    #2 reset = 1'b0;
    #1;
    strb  = {busy, done, we, ac_reset, ac_oen, neu_ien, sel};
    addrs = {w_addr, in_addr, u_rd, u_wr, spk_wr};
    total++;
    if (strb !== 7'd0 || addrs !== 45'd0)
      $display("FAIL async_reset strb=%b addr=%h want 0",
               strb, addrs);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0)
      $display("FAIL after_reset busy=%b want 0", busy);
    else passed++;
  endtask

  task automatic test_start_held();
    int n_done, first;
    n_done = 0;
    first = 0;
    start = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (done) begin
        n_done++;
        if (first == 0) first = c;
      end
      if (c == 20) start = 1'b0;
    end
    total++;
    if (n_done != 1 || first != 29)
      $display("FAIL start_held dones=%0d first=%0d want 1/29",
               n_done, first);
    else passed++;
    total++;
    if (busy !== 1'b0)
      $display("FAIL start_held_end busy=%b want 0", busy);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_abort();
    test_async_reset();
    test_start_held();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
